// File: rtl/serial_sync_tx.sv
// Bit-serial frame transmitter: "11" sync marker, MSB-first payload with a 0
// stuffed after every payload 1, then a single gap 0. Idle line is 0.
module serial_sync_tx #(
    parameter int unsigned DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              out,
    output logic              busy,
    output logic              frame_done
);

    localparam int unsigned CNT_W = $clog2(DATA_W + 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SYNC0 = 3'd1,
        SYNC1 = 3'd2,
        DATA  = 3'd3,
        STUFF = 3'd4,
        GAP   = 3'd5
    } state_t;

    state_t            state_q, state_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic [CNT_W-1:0]  cnt_q,   cnt_d;
    logic              out_q,   out_d;
    logic              busy_q,  busy_d;
    logic              done_q,  done_d;

    // Ready is gated by rst directly so a word offered during reset is never taken.
    assign in_ready = (state_q == IDLE) && !rst;

    // Next-state, shift register and bit counter.
    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (in_valid && in_ready) begin
                    shift_d = in_data;
                    cnt_d   = CNT_W'(DATA_W);
                    state_d = SYNC0;
                end
            end
            SYNC0: state_d = SYNC1;
            SYNC1: state_d = DATA;
            DATA: begin
                shift_d = shift_q << 1;
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
                if (shift_q[DATA_W-1]) begin
                    state_d = STUFF;
                end else if (cnt_d == '0) begin
                    state_d = GAP;
                end
            end
            STUFF:   state_d = (cnt_q == '0) ? GAP : DATA;
            GAP:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Outputs decoded from the upcoming state so they register alongside it.
    always_comb begin
        out_d  = 1'b0;
        busy_d = (state_d != IDLE);
        done_d = (state_d == GAP);
        case (state_d)
            SYNC0, SYNC1: out_d = 1'b1;
            DATA:         out_d = shift_d[DATA_W-1];
            default:      out_d = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            shift_q <= '0;
            cnt_q   <= '0;
            out_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            cnt_q   <= cnt_d;
            out_q   <= out_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign out        = out_q;
    assign busy       = busy_q;
    assign frame_done = done_q;

endmodule

// File: tb/tb_serial_sync_tx.sv
// Directed bench for serial_sync_tx: frame shapes, back-to-back accept,
// mid-frame reset and valid-during-reset behaviour.
module tb_serial_sync_tx;

    logic       clk;
    logic       rst;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_ready;
    logic       out;
    logic       busy;
    logic       frame_done;

    int n_checks;
    int n_fail;

    serial_sync_tx #(.DATA_W(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .out        (out),
        .busy       (busy),
        .frame_done (frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic test_reset();
        rst      = 1'b1;
        in_valid = 1'b0;
        in_data  = 8'h00;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_checks++; if (out !== 1'b0)        begin n_fail++; $display("FAIL reset_out got=%b exp=0", out); end
        n_checks++; if (busy !== 1'b0)       begin n_fail++; $display("FAIL reset_busy got=%b exp=0", busy); end
        n_checks++; if (frame_done !== 1'b0) begin n_fail++; $display("FAIL reset_done got=%b exp=0", frame_done); end
        n_checks++; if (in_ready !== 1'b0)   begin n_fail++; $display("FAIL reset_ready got=%b exp=0", in_ready); end
        rst = 1'b0;
        #1;
        n_checks++; if (in_ready !== 1'b1)   begin n_fail++; $display("FAIL reset_ready_release got=%b exp=1", in_ready); end
        @(negedge clk);
        n_checks++; if (busy !== 1'b0)       begin n_fail++; $display("FAIL reset_idle_busy got=%b exp=0", busy); end
    endtask

    task automatic test_single_frames();
        logic [7:0]  dat [3];
        int          len [3];
        logic [31:0] pat [3];
        logic [31:0] p;
        logic        expb;
        dat = '{8'h00, 8'hFF, 8'hA5};
        len = '{11, 19, 15};
        pat = '{32'b11000000000, 32'b1110101010101010100, 32'b111001000100100};
        for (int t = 0; t < 3; t++) begin
            p = pat[t];
            n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL frame%0d_pre_ready got=%b exp=1", t, in_ready); end
            in_data  = dat[t];
            in_valid = 1'b1;
            @(posedge clk);
            #1;
            in_valid = 1'b0;
            in_data  = 8'h5A;
            for (int i = 0; i < len[t]; i++) begin
                @(negedge clk);
                expb = p[len[t]-1-i];
                n_checks++; if (out !== expb) begin n_fail++; $display("FAIL frame%0d_out cyc=%0d got=%b exp=%b", t, i, out, expb); end
                n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL frame%0d_busy cyc=%0d got=%b exp=1", t, i, busy); end
                n_checks++; if (frame_done !== (i == len[t]-1)) begin n_fail++; $display("FAIL frame%0d_done cyc=%0d got=%b exp=%b", t, i, frame_done, (i == len[t]-1)); end
            end
            @(negedge clk);
            n_checks++; if (busy !== 1'b0)       begin n_fail++; $display("FAIL frame%0d_post_busy got=%b exp=0", t, busy); end
            n_checks++; if (out !== 1'b0)        begin n_fail++; $display("FAIL frame%0d_post_out got=%b exp=0", t, out); end
            n_checks++; if (frame_done !== 1'b0) begin n_fail++; $display("FAIL frame%0d_post_done got=%b exp=0", t, frame_done); end
            n_checks++; if (in_ready !== 1'b1)   begin n_fail++; $display("FAIL frame%0d_post_ready got=%b exp=1", t, in_ready); end
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] p1;
        logic [31:0] p2;
        logic        expb;
        int          run;
        int          flags;
        p1    = 32'b1110000000100;
        p2    = 32'b110000000100;
        run   = 0;
        flags = 0;
        in_data  = 8'h81;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_data = 8'h01;
        for (int i = 0; i < 13; i++) begin
            @(negedge clk);
            expb = p1[12-i];
            n_checks++; if (out !== expb) begin n_fail++; $display("FAIL b2b_f1_out cyc=%0d got=%b exp=%b", i, out, expb); end
            n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL b2b_f1_ready cyc=%0d got=%b exp=0", i, in_ready); end
            n_checks++; if (frame_done !== (i == 12)) begin n_fail++; $display("FAIL b2b_f1_done cyc=%0d got=%b exp=%b", i, frame_done, (i == 12)); end
            run = (out === 1'b1) ? run + 1 : 0;
            if (run == 2) flags++;
        end
        n_checks++; if (flags !== 1) begin n_fail++; $display("FAIL b2b_f1_flags got=%0d exp=1", flags); end
        @(negedge clk);
        n_checks++; if (busy !== 1'b0)     begin n_fail++; $display("FAIL b2b_gap_busy got=%b exp=0", busy); end
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_gap_ready got=%b exp=1", in_ready); end
        n_checks++; if (out !== 1'b0)      begin n_fail++; $display("FAIL b2b_gap_out got=%b exp=0", out); end
        run = (out === 1'b1) ? run + 1 : 0;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            expb = p2[11-i];
            n_checks++; if (out !== expb) begin n_fail++; $display("FAIL b2b_f2_out cyc=%0d got=%b exp=%b", i, out, expb); end
            n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL b2b_f2_busy cyc=%0d got=%b exp=1", i, busy); end
            n_checks++; if (frame_done !== (i == 11)) begin n_fail++; $display("FAIL b2b_f2_done cyc=%0d got=%b exp=%b", i, frame_done, (i == 11)); end
            run = (out === 1'b1) ? run + 1 : 0;
            if (run == 2) flags++;
        end
        n_checks++; if (flags !== 2) begin n_fail++; $display("FAIL b2b_total_flags got=%0d exp=2", flags); end
        @(negedge clk);
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL b2b_post_busy got=%b exp=0", busy); end
    endtask

    task automatic test_mid_reset();
        logic [31:0] p;
        logic        expb;
        p = 32'b11101;
        in_data  = 8'hFF;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            expb = p[4-i];
            n_checks++; if (out !== expb) begin n_fail++; $display("FAIL midrst_out cyc=%0d got=%b exp=%b", i, out, expb); end
            n_checks++; if (frame_done !== 1'b0) begin n_fail++; $display("FAIL midrst_done cyc=%0d got=%b exp=0", i, frame_done); end
        end
        rst      = 1'b1;
        in_valid = 1'b1;
        @(negedge clk);
        n_checks++; if (out !== 1'b0)        begin n_fail++; $display("FAIL midrst_after_out got=%b exp=0", out); end
        n_checks++; if (busy !== 1'b0)       begin n_fail++; $display("FAIL midrst_after_busy got=%b exp=0", busy); end
        n_checks++; if (frame_done !== 1'b0) begin n_fail++; $display("FAIL midrst_after_done got=%b exp=0", frame_done); end
        n_checks++; if (in_ready !== 1'b0)   begin n_fail++; $display("FAIL midrst_in_rst_ready got=%b exp=0", in_ready); end
        rst      = 1'b0;
        in_valid = 1'b0;
        #1;
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL midrst_release_ready got=%b exp=1", in_ready); end
        @(negedge clk);
        n_checks++; if (busy !== 1'b0)       begin n_fail++; $display("FAIL midrst_idle_busy got=%b exp=0", busy); end
        n_checks++; if (frame_done !== 1'b0) begin n_fail++; $display("FAIL midrst_idle_done got=%b exp=0", frame_done); end
        p = 32'b11000000000;
        in_data  = 8'h00;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        for (int i = 0; i < 11; i++) begin
            @(negedge clk);
            expb = p[10-i];
            n_checks++; if (out !== expb) begin n_fail++; $display("FAIL midrst_next_out cyc=%0d got=%b exp=%b", i, out, expb); end
            n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL midrst_next_busy cyc=%0d got=%b exp=1", i, busy); end
            n_checks++; if (frame_done !== (i == 10)) begin n_fail++; $display("FAIL midrst_next_done cyc=%0d got=%b exp=%b", i, frame_done, (i == 10)); end
        end
        @(negedge clk);
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL midrst_next_post_busy got=%b exp=0", busy); end
    endtask

    task automatic test_valid_during_reset();
        rst      = 1'b1;
        in_valid = 1'b1;
        in_data  = 8'hFF;
        #1;
        n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL vrst_ready_now got=%b exp=0", in_ready); end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL vrst_ready cyc=%0d got=%b exp=0", i, in_ready); end
            n_checks++; if (busy !== 1'b0)     begin n_fail++; $display("FAIL vrst_busy cyc=%0d got=%b exp=0", i, busy); end
            n_checks++; if (out !== 1'b0)      begin n_fail++; $display("FAIL vrst_out cyc=%0d got=%b exp=0", i, out); end
        end
        rst      = 1'b0;
        in_valid = 1'b0;
        #1;
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL vrst_release_ready got=%b exp=1", in_ready); end
        @(negedge clk);
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL vrst_post_busy got=%b exp=0", busy); end
        n_checks++; if (out !== 1'b0)  begin n_fail++; $display("FAIL vrst_post_out got=%b exp=0", out); end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst      = 1'b1;
        in_valid = 1'b0;
        in_data  = 8'h00;
        test_reset();
        test_single_frames();
        test_back_to_back();
        test_mid_reset();
        test_valid_during_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
